// File: rtl/tpg_gen.sv
// Pipelined VGA test pattern generator with eight patterns, per-frame scrolling and
// 2-cycle aligned sync/de outputs. Sits between vga_timing and the pin/DAC stage.
module tpg_gen #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int RW          = 3,
   parameter int GW          = 3,
   parameter int BW          = 2,
   parameter int GRID_SHIFT  = 5,
   parameter int CHK_SHIFT   = 4,
   parameter int SCROLL_STEP = 1
) (
   input  logic          clk_pix,
   input  logic          resetn,
   input  logic [9:0]    hcount,
   input  logic [9:0]    vcount,
   input  logic          de,
   input  logic          hsync_in,
   input  logic          vsync_in,
   input  logic [2:0]    mode,
   input  logic          anim_en,
   output logic [RW-1:0] rgb_r,
   output logic [GW-1:0] rgb_g,
   output logic [BW-1:0] rgb_b,
   output logic          hsync_out,
   output logic          vsync_out,
   output logic          de_out,
   output logic [7:0]    frame_cnt
);

   localparam int BAR_W = H_ACTIVE / 8;

   logic [2:0]  active_mode_reg;
   logic [9:0]  offset_reg;
   logic        frame_edge;
   logic [7:0]  frame_cnt_next;
   logic [9:0]  offset_next;
   logic [10:0] x_sum;
   logic [9:0]  x_eff;
   logic [7:1]  bar_ge;
   logic [2:0]  bar_idx;
   logic [2:0]  bar_code;

   assign frame_edge     = (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);
   assign frame_cnt_next = frame_cnt + 8'd1;
   assign offset_next    = anim_en ? 10'((int'(frame_cnt_next) * SCROLL_STEP) % H_ACTIVE) : 10'd0;

   always_ff @(posedge clk_pix or negedge resetn) begin
      if (!resetn) begin
         frame_cnt       <= 8'd0;
         active_mode_reg <= 3'd0;
         offset_reg      <= 10'd0;
      end else if (frame_edge) begin
         frame_cnt       <= frame_cnt_next;
         active_mode_reg <= mode;
         offset_reg      <= offset_next;
      end
   end

   // Out-of-range hcount (blanking or misbehaving timing) still wraps into the active width.
   assign x_sum = {1'b0, hcount} + {1'b0, offset_reg};
   assign x_eff = 10'(x_sum % 11'(H_ACTIVE));

   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_bar_cmp
         assign bar_ge[gi] = (x_eff >= 10'(gi * BAR_W));
      end
   endgenerate

   always_comb begin
      bar_idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         bar_idx = bar_idx + {2'b00, bar_ge[i]};
      end
   end

   always_comb begin
      case (bar_idx)
         3'd0:    bar_code = 3'd7;
         3'd1:    bar_code = 3'd6;
         3'd2:    bar_code = 3'd3;
         3'd3:    bar_code = 3'd2;
         3'd4:    bar_code = 3'd5;
         3'd5:    bar_code = 3'd4;
         3'd6:    bar_code = 3'd1;
         default: bar_code = 3'd0;
      endcase
   end

   // Stage 1: decoded pattern terms plus delayed timing signals.
   logic          de_s1, hs_s1, vs_s1;
   logic [2:0]    mode_s1, bar_s1, solid_s1;
   logic          grid_s1, chk_s1, cell_s1, border_s1;
   logic [RW-1:0] hr_r_s1;
   logic [GW-1:0] hr_g_s1, vr_g_s1;
   logic [BW-1:0] hr_b_s1;

   always_ff @(posedge clk_pix or negedge resetn) begin
      if (!resetn) begin
         de_s1     <= 1'b0;
         hs_s1     <= 1'b0;
         vs_s1     <= 1'b0;
         mode_s1   <= 3'd0;
         bar_s1    <= 3'd0;
         solid_s1  <= 3'd0;
         grid_s1   <= 1'b0;
         chk_s1    <= 1'b0;
         cell_s1   <= 1'b0;
         border_s1 <= 1'b0;
         hr_r_s1   <= '0;
         hr_g_s1   <= '0;
         hr_b_s1   <= '0;
         vr_g_s1   <= '0;
      end else begin
         de_s1     <= de;
         hs_s1     <= hsync_in;
         vs_s1     <= vsync_in;
         mode_s1   <= active_mode_reg;
         bar_s1    <= bar_code;
         solid_s1  <= anim_en ? frame_cnt[7:5] : 3'd7;
         grid_s1   <= (hcount[GRID_SHIFT-1:0] == '0) || (vcount[GRID_SHIFT-1:0] == '0) ||
                      (hcount == 10'(H_ACTIVE - 1)) || (vcount == 10'(V_ACTIVE - 1));
         chk_s1    <= x_eff[CHK_SHIFT] ^ vcount[CHK_SHIFT];
         cell_s1   <= (hcount[2:0] == 3'd0) && (vcount[3:0] == 4'd0);
         border_s1 <= (hcount == 10'd0) || (hcount == 10'(H_ACTIVE - 1)) ||
                      (vcount == 10'd0) || (vcount == 10'(V_ACTIVE - 1));
         hr_r_s1   <= x_eff[9 -: RW];
         hr_g_s1   <= x_eff[9 -: GW];
         hr_b_s1   <= x_eff[9 -: BW];
         vr_g_s1   <= vcount[8 -: GW];
      end
   end

   logic [2:0]    code_next;
   logic [RW-1:0] col_r_next;
   logic [GW-1:0] col_g_next;
   logic [BW-1:0] col_b_next;

   always_comb begin
      code_next = 3'd0;
      case (mode_s1)
         3'd0:    code_next = bar_s1;
         3'd1:    code_next = grid_s1 ? 3'd7 : 3'd0;
         3'd2:    code_next = chk_s1 ? 3'd7 : 3'd0;
         3'd3:    code_next = cell_s1 ? 3'd2 : 3'd0;
         3'd6:    code_next = solid_s1;
         3'd7:    code_next = border_s1 ? 3'd7 : 3'd0;
         default: code_next = 3'd0;
      endcase
      col_r_next = {RW{code_next[2]}};
      col_g_next = {GW{code_next[1]}};
      col_b_next = {BW{code_next[0]}};
      // Ramp modes bypass the colour code entirely.
      if (mode_s1 == 3'd4) begin
         col_r_next = hr_r_s1;
         col_g_next = hr_g_s1;
         col_b_next = hr_b_s1;
      end else if (mode_s1 == 3'd5) begin
         col_r_next = '0;
         col_g_next = vr_g_s1;
         col_b_next = '0;
      end
   end

   // Stage 2: final colour, blanked outside the active area.
   always_ff @(posedge clk_pix or negedge resetn) begin
      if (!resetn) begin
         rgb_r     <= '0;
         rgb_g     <= '0;
         rgb_b     <= '0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
         de_out    <= 1'b0;
      end else begin
         rgb_r     <= de_s1 ? col_r_next : '0;
         rgb_g     <= de_s1 ? col_g_next : '0;
         rgb_b     <= de_s1 ? col_b_next : '0;
         hsync_out <= hs_s1;
         vsync_out <= vs_s1;
         de_out    <= de_s1;
      end
   end

endmodule
